gio_port_bank: RTL and testbench

//  Parametrised PicoBlaze I/O bank that replaces single-address in/out ports.

---
 rtl/gio_port_bank.sv | 143 ++++++++++++++
 tb/tb_gio_port_bank.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/gio_port_bank.sv
// rtl/gio_port_bank.sv - PicoBlaze port-mapped GPIO bank with read-back outputs,
// synchronised inputs, sticky edge flags, interrupt mask and registered irq.
module gio_port_bank #(
  parameter logic [7:0] BASE_ADDR   = 8'h00,
  parameter int         NUM_OUT     = 1,
  parameter int         NUM_IN      = 1,
  parameter int         SYNC_STAGES = 2,
  parameter int         EDGE_MODE   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           address,
  input  logic [7:0]           value_in,
  input  logic                 wen,
  input  logic                 ren,
  output logic [7:0]           value_out,
  input  logic [8*NUM_IN-1:0]  pins_in,
  output logic [8*NUM_OUT-1:0] pins_out,
  output logic                 irq
);

  localparam logic [1:0] GRP_OUT  = 2'd0;
  localparam logic [1:0] GRP_IN   = 2'd1;
  localparam logic [1:0] GRP_EDGE = 2'd2;
  localparam logic [1:0] GRP_MASK = 2'd3;

  if (BASE_ADDR[5:0] != 6'd0) begin : g_bad_base
    $error("gio_port_bank: BASE_ADDR must be 64-aligned");
  end
  if (NUM_OUT < 1 || NUM_OUT > 16) begin : g_bad_out
    $error("gio_port_bank: NUM_OUT must be 1..16");
  end
  if (NUM_IN < 1 || NUM_IN > 16) begin : g_bad_in
    $error("gio_port_bank: NUM_IN must be 1..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("gio_port_bank: SYNC_STAGES must be >= 2");
  end
  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
    $error("gio_port_bank: EDGE_MODE must be 0, 1 or 2");
  end

  logic [7:0] r_out   [NUM_OUT];
  logic [7:0] r_sync  [NUM_IN][SYNC_STAGES];
  logic [7:0] r_hist  [NUM_IN];
  logic [7:0] r_edge  [NUM_IN];
  logic [7:0] r_imask [NUM_IN];
  logic [7:0] r_value_out;
  logic       r_irq;

  logic       w_hit;
  logic [1:0] w_grp;
  logic [3:0] w_idx;
  logic       w_wr_out;
  logic       w_wr_edge;
  logic       w_wr_mask;
  logic [7:0] w_in  [NUM_IN];
  logic [7:0] w_set [NUM_IN];
  logic [7:0] w_rdata;
  logic       w_irq_next;

  // BASE_ADDR is 64-aligned, so the offset is simply the low six address bits.
  assign w_hit     = (address[7:6] == BASE_ADDR[7:6]);
  assign w_grp     = address[5:4];
  assign w_idx     = address[3:0];
  assign w_wr_out  = wen && w_hit && (w_grp == GRP_OUT);
  assign w_wr_edge = wen && w_hit && (w_grp == GRP_EDGE);
  assign w_wr_mask = wen && w_hit && (w_grp == GRP_MASK);

  for (genvar j = 0; j < NUM_IN; j++) begin : g_in
    assign w_in[j] = r_sync[j][SYNC_STAGES-1];
    if (EDGE_MODE == 0) begin : g_rise
      assign w_set[j] = w_in[j] & ~r_hist[j];
    end else if (EDGE_MODE == 1) begin : g_fall
      assign w_set[j] = ~w_in[j] & r_hist[j];
    end else begin : g_both
      assign w_set[j] = w_in[j] ^ r_hist[j];
    end
  end

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
    assign pins_out[8*i +: 8] = r_out[i];
  end

  always_comb begin
    w_rdata    = 8'h00;
    w_irq_next = 1'b0;
    if (w_hit) begin
      case (w_grp)
        GRP_OUT: begin
          for (int i = 0; i < NUM_OUT; i++)
            if (w_idx == i[3:0]) w_rdata = r_out[i];
        end
        GRP_IN: begin
          for (int j = 0; j < NUM_IN; j++)
            if (w_idx == j[3:0]) w_rdata = w_in[j];
        end
        GRP_EDGE: begin
          for (int j = 0; j < NUM_IN; j++)
            if (w_idx == j[3:0]) w_rdata = r_edge[j];
        end
        default: begin
          for (int j = 0; j < NUM_IN; j++)
            if (w_idx == j[3:0]) w_rdata = r_imask[j];
        end
      endcase
    end
    for (int j = 0; j < NUM_IN; j++)
      w_irq_next = w_irq_next | (|(r_edge[j] & r_imask[j]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_OUT; i++) r_out[i] <= 8'h00;
      for (int j = 0; j < NUM_IN; j++) begin
        for (int s = 0; s < SYNC_STAGES; s++) r_sync[j][s] <= 8'h00;
        r_hist[j]  <= 8'h00;
        r_edge[j]  <= 8'h00;
        r_imask[j] <= 8'h00;
      end
      r_value_out <= 8'h00;
      r_irq       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++)
        if (w_wr_out && (w_idx == i[3:0])) r_out[i] <= value_in;
      for (int j = 0; j < NUM_IN; j++) begin
        r_sync[j][0] <= pins_in[8*j +: 8];
        for (int s = 1; s < SYNC_STAGES; s++) r_sync[j][s] <= r_sync[j][s-1];
        r_hist[j] <= w_in[j];
        if (w_wr_mask && (w_idx == j[3:0])) r_imask[j] <= value_in;
        // A new edge is OR-ed in after the clear, so a simultaneous set survives.
        r_edge[j] <= (r_edge[j] & ~((w_wr_edge && (w_idx == j[3:0])) ? value_in : 8'h00))
                     | w_set[j];
      end
      if (ren) r_value_out <= w_rdata;
      r_irq <= w_irq_next;
    end
  end

  assign value_out = r_value_out;
  assign irq       = r_irq;

endmodule

// File: tb/tb_gio_port_bank.sv
// tb/tb_gio_port_bank.sv - table-driven bench for gio_port_bank (rising-edge bank
// at 0x40 plus a both-edges bank at 0x00).
module tb_gio_port_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_wen, a_ren, a_irq;
  logic [7:0]  a_addr, a_wd, a_vo;
  logic [15:0] a_pins, a_po;
  logic        b_wen, b_ren, b_irq;
  logic [7:0]  b_addr, b_wd, b_vo, b_pins, b_po;

  int checks = 0;
  int errors = 0;

  gio_port_bank #(
    .BASE_ADDR(8'h40), .NUM_OUT(2), .NUM_IN(2), .SYNC_STAGES(2), .EDGE_MODE(0)
  ) u_a (
    .clk(clk), .rst(rst), .address(a_addr), .value_in(a_wd), .wen(a_wen),
    .ren(a_ren), .value_out(a_vo), .pins_in(a_pins), .pins_out(a_po), .irq(a_irq)
  );

  gio_port_bank #(
    .BASE_ADDR(8'h00), .NUM_OUT(1), .NUM_IN(1), .SYNC_STAGES(2), .EDGE_MODE(2)
  ) u_b (
    .clk(clk), .rst(rst), .address(b_addr), .value_in(b_wd), .wen(b_wen),
    .ren(b_ren), .value_out(b_vo), .pins_in(b_pins), .pins_out(b_po), .irq(b_irq)
  );

  typedef struct {
    logic        wen;
    logic        ren;
    logic [7:0]  addr;
    logic [7:0]  wd;
    logic [15:0] pins;
    logic [7:0]  vo;
    logic [15:0] po;
    logic        irq;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string nm, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic r, input logic [7:0] ad,
                     input logic [7:0] wd, input logic [15:0] p, input logic [7:0] vo,
                     input logic [15:0] po, input logic irq);
    vq.push_back('{w, r, ad, wd, p, vo, po, irq});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_op(input logic w, input logic r, input logic [7:0] ad,
                      input logic [7:0] wd);
    b_wen = w; b_ren = r; b_addr = ad; b_wd = wd;
    tick();
    b_wen = 1'b0; b_ren = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    a_wen = 1'b0; a_ren = 1'b0; a_addr = 8'h00; a_wd = 8'h00; a_pins = 16'h0000;
    b_wen = 1'b0; b_ren = 1'b0; b_addr = 8'h00; b_wd = 8'h00; b_pins = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_vo", 0, a_vo, 16'h0);
    check("rst_a_po", 0, a_po, 16'h0);
    check("rst_a_irq", 0, a_irq, 16'h0);
    check("rst_b_vo", 0, b_vo, 16'h0);
    check("rst_b_po", 0, b_po, 16'h0);
    check("rst_b_irq", 0, b_irq, 16'h0);
    rst = 1'b1;

    //   wen  ren  addr   wd     pins      vo     po        irq
    add(1, 0, 8'h41, 8'hA5, 16'h0000, 8'h00, 16'hA500, 0);
    add(0, 1, 8'h41, 8'h00, 16'h0000, 8'hA5, 16'hA500, 0);
    add(1, 0, 8'h40, 8'h3C, 16'h0000, 8'hA5, 16'hA53C, 0);
    add(0, 1, 8'h40, 8'h00, 16'h0000, 8'h3C, 16'hA53C, 0);
    add(1, 0, 8'h01, 8'hFF, 16'h0000, 8'h3C, 16'hA53C, 0);
    add(1, 1, 8'h42, 8'hFF, 16'h0000, 8'h00, 16'hA53C, 0);
    add(1, 1, 8'h40, 8'h77, 16'h0000, 8'h3C, 16'hA577, 0);
    add(0, 0, 8'h00, 8'h00, 16'h0081, 8'h3C, 16'hA577, 0);
    add(0, 0, 8'h00, 8'h00, 16'h0081, 8'h3C, 16'hA577, 0);
    add(0, 1, 8'h50, 8'h00, 16'h0081, 8'h81, 16'hA577, 0);
    add(0, 1, 8'h60, 8'h00, 16'h0081, 8'h81, 16'hA577, 0);
    add(0, 1, 8'h61, 8'h00, 16'h0081, 8'h00, 16'hA577, 0);
    add(1, 0, 8'h70, 8'h01, 16'h0081, 8'h00, 16'hA577, 0);
    add(0, 0, 8'h00, 8'h00, 16'h0081, 8'h00, 16'hA577, 1);
    add(1, 0, 8'h60, 8'h01, 16'h0081, 8'h00, 16'hA577, 1);
    add(0, 1, 8'h60, 8'h00, 16'h0081, 8'h80, 16'hA577, 0);
    add(1, 0, 8'h60, 8'h02, 16'h0081, 8'h80, 16'hA577, 0);
    add(0, 1, 8'h60, 8'h00, 16'h0081, 8'h80, 16'hA577, 0);
    add(1, 0, 8'h50, 8'hFF, 16'h0081, 8'h80, 16'hA577, 0);
    add(0, 1, 8'h50, 8'h00, 16'h0081, 8'h81, 16'hA577, 0);
    add(0, 0, 8'h00, 8'h00, 16'h0080, 8'h81, 16'hA577, 0);
    add(0, 0, 8'h00, 8'h00, 16'h0080, 8'h81, 16'hA577, 0);
    add(0, 0, 8'h00, 8'h00, 16'h0080, 8'h81, 16'hA577, 0);
    add(0, 1, 8'h60, 8'h00, 16'h0081, 8'h80, 16'hA577, 0);
    add(0, 0, 8'h00, 8'h00, 16'h0081, 8'h80, 16'hA577, 0);
    add(0, 0, 8'h00, 8'h00, 16'h0081, 8'h80, 16'hA577, 0);
    add(0, 0, 8'h00, 8'h00, 16'h0080, 8'h80, 16'hA577, 1);
    add(0, 0, 8'h00, 8'h00, 16'h0080, 8'h80, 16'hA577, 1);
    add(0, 0, 8'h00, 8'h00, 16'h0081, 8'h80, 16'hA577, 1);
    add(0, 0, 8'h00, 8'h00, 16'h0081, 8'h80, 16'hA577, 1);
    add(1, 0, 8'h60, 8'h01, 16'h0081, 8'h80, 16'hA577, 1);
    add(0, 1, 8'h60, 8'h00, 16'h0081, 8'h81, 16'hA577, 1);
    add(0, 0, 8'h00, 8'h00, 16'h0081, 8'h81, 16'hA577, 1);
    add(1, 0, 8'h70, 8'h00, 16'h0081, 8'h81, 16'hA577, 1);
    add(0, 0, 8'h00, 8'h00, 16'h0081, 8'h81, 16'hA577, 0);
    add(0, 0, 8'h00, 8'h00, 16'h0281, 8'h81, 16'hA577, 0);
    add(0, 0, 8'h00, 8'h00, 16'h0281, 8'h81, 16'hA577, 0);
    add(0, 0, 8'h00, 8'h00, 16'h0281, 8'h81, 16'hA577, 0);
    add(0, 1, 8'h61, 8'h00, 16'h0281, 8'h02, 16'hA577, 0);
    add(0, 1, 8'h7F, 8'h00, 16'h0281, 8'h00, 16'hA577, 0);
    add(0, 1, 8'h51, 8'h00, 16'h0281, 8'h02, 16'hA577, 0);
    add(0, 1, 8'hC0, 8'h00, 16'h0281, 8'h00, 16'hA577, 0);

    for (int k = 0; k < vq.size(); k++) begin
      a_wen = vq[k].wen; a_ren = vq[k].ren; a_addr = vq[k].addr;
      a_wd = vq[k].wd; a_pins = vq[k].pins;
      tick();
      check("vec_vo", k, a_vo, vq[k].vo);
      check("vec_po", k, a_po, vq[k].po);
      check("vec_irq", k, a_irq, vq[k].irq);
    end
    a_wen = 1'b0; a_ren = 1'b0;

    // Both-edges bank: pins held high through reset left a start-up flag.
    b_op(0, 1, 8'h20, 8'h00);
    check("b_startup_edge", 0, b_vo, 16'h00FF);
    b_op(1, 0, 8'h20, 8'hFF);
    b_op(0, 1, 8'h20, 8'h00);
    check("b_edge_cleared", 0, b_vo, 16'h0000);
    b_pins = 8'hF7;
    repeat (3) tick();
    b_op(0, 1, 8'h20, 8'h00);
    check("b_fall_edge", 0, b_vo, 16'h0008);
    b_op(0, 1, 8'h3F, 8'h00);
    check("b_rd_3f", 0, b_vo, 16'h0000);
    b_op(0, 1, 8'h20, 8'h00);
    check("b_fall_edge", 1, b_vo, 16'h0008);
    b_op(0, 1, 8'h1F, 8'h00);
    check("b_rd_1f", 0, b_vo, 16'h0000);
    b_op(1, 0, 8'h10, 8'hFF);
    b_op(0, 1, 8'h10, 8'h00);
    check("b_in_ro", 0, b_vo, 16'h00F7);
    b_op(1, 0, 8'h00, 8'hFF);
    check("b_out_po", 0, b_po, 16'h00FF);
    b_op(1, 0, 8'h30, 8'h08);
    check("b_irq_lag", 0, b_irq, 16'h0);
    b_op(0, 0, 8'h00, 8'h00);
    check("b_irq_set", 0, b_irq, 16'h1);

    // Asynchronous reset in the middle of a read cycle.
    a_ren = 1'b1; a_addr = 8'h40;
    b_ren = 1'b1; b_addr = 8'h00;
    #3;
    rst = 1'b0;
    #1;
    check("arst_a_vo", 0, a_vo, 16'h0);
    check("arst_a_po", 0, a_po, 16'h0);
    check("arst_b_vo", 0, b_vo, 16'h0);
    check("arst_b_po", 0, b_po, 16'h0);
    check("arst_b_irq", 0, b_irq, 16'h0);
    tick();
    check("arst_hold_b_vo", 0, b_vo, 16'h0);
    check("arst_hold_a_vo", 0, a_vo, 16'h0);
    rst = 1'b1;
    a_ren = 1'b1; a_addr = 8'h41;
    b_ren = 1'b0;
    tick();
    a_ren = 1'b0;
    check("post_rst_out1", 0, a_vo, 16'h0);
    check("post_rst_po", 0, a_po, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
